// File: rtl/sync_ram_tdp.sv
// True-dual-port byte-enabled RAM: 1-edge read latency (2 with OUT_REG_x), per-port RDW mode, port A wins write/write lanes.
// No backpressure; each port advances only on its clken and q holds while clken is low.
module sync_ram_tdp #(
   parameter int    DATA_W    = 8,
   parameter int    ADDR_W    = 10,
   parameter int    DEPTH     = 1024,
   parameter int    BYTE_W    = 8,
   parameter int    OUT_REG_A = 0,
   parameter int    OUT_REG_B = 0,
   parameter string RDW_A     = "NEW_DATA",
   parameter string RDW_B     = "NEW_DATA",
   parameter string INIT_FILE = ""
) (
   input  logic                     clock0,
   input  logic                     aclr0_n,
   input  logic                     clken_a,
   input  logic                     wren_a,
   input  logic                     rden_a,
   input  logic [ADDR_W-1:0]        address_a,
   input  logic [DATA_W-1:0]        data_a,
   input  logic [DATA_W/BYTE_W-1:0] byteena_a,
   output logic [DATA_W-1:0]        q_a,
   input  logic                     clken_b,
   input  logic                     wren_b,
   input  logic                     rden_b,
   input  logic [ADDR_W-1:0]        address_b,
   input  logic [DATA_W-1:0]        data_b,
   input  logic [DATA_W/BYTE_W-1:0] byteena_b,
   output logic [DATA_W-1:0]        q_b,
   output logic                     collision
);
   localparam int NBE   = DATA_W / BYTE_W;
   localparam bit OLD_A = (RDW_A == "OLD_DATA");
   localparam bit OLD_B = (RDW_B == "OLD_DATA");

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [DATA_W-1:0] r_rd_a;
   logic [DATA_W-1:0] r_rd_b;
   logic              r_collision;
   logic              w_inr_a;
   logic              w_inr_b;
   logic              w_wr_a;
   logic              w_wr_b;
   logic              w_same_addr;

   function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [NBE-1:0]    be);
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int l = 0; l < NBE; l++) begin
         if (be[l]) res[l*BYTE_W +: BYTE_W] = new_w[l*BYTE_W +: BYTE_W];
      end
      return res;
   endfunction

   // When the array fills the whole address space every address is legal.
   generate
      if (DEPTH >= (2 ** ADDR_W)) begin : g_full
         assign w_inr_a = 1'b1;
         assign w_inr_b = 1'b1;
      end else begin : g_part
         localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
         assign w_inr_a = ({1'b0, address_a} < LIMIT);
         assign w_inr_b = ({1'b0, address_b} < LIMIT);
      end
   endgenerate

   assign w_wr_a      = aclr0_n & clken_a & wren_a & w_inr_a;
   assign w_wr_b      = aclr0_n & clken_b & wren_b & w_inr_b;
   assign w_same_addr = (address_a == address_b);

   always_ff @(posedge clock0) begin
      for (int l = 0; l < NBE; l++) begin
         if (w_wr_b && byteena_b[l] && !(w_wr_a && byteena_a[l] && w_same_addr))
            r_mem[address_b][l*BYTE_W +: BYTE_W] <= data_b[l*BYTE_W +: BYTE_W];
         if (w_wr_a && byteena_a[l])
            r_mem[address_a][l*BYTE_W +: BYTE_W] <= data_a[l*BYTE_W +: BYTE_W];
      end
   end

   // Reads sample the array before this edge's writes, so the other port always sees old data.
   always_ff @(posedge clock0 or negedge aclr0_n) begin
      if (!aclr0_n) begin
         r_rd_a <= '0;
      end else if (clken_a && rden_a) begin
         if (!w_inr_a)               r_rd_a <= '0;
         else if (wren_a && !OLD_A)  r_rd_a <= f_merge(r_mem[address_a], data_a, byteena_a);
         else                        r_rd_a <= r_mem[address_a];
      end
   end

   always_ff @(posedge clock0 or negedge aclr0_n) begin
      if (!aclr0_n) begin
         r_rd_b <= '0;
      end else if (clken_b && rden_b) begin
         if (!w_inr_b)               r_rd_b <= '0;
         else if (wren_b && !OLD_B)  r_rd_b <= f_merge(r_mem[address_b], data_b, byteena_b);
         else                        r_rd_b <= r_mem[address_b];
      end
   end

   always_ff @(posedge clock0 or negedge aclr0_n) begin
      if (!aclr0_n) r_collision <= 1'b0;
      else          r_collision <= w_wr_a & w_wr_b & w_same_addr;
   end

   assign collision = r_collision;

   generate
      if (OUT_REG_A != 0) begin : g_oreg_a
         logic [DATA_W-1:0] r_out_a;
         always_ff @(posedge clock0 or negedge aclr0_n) begin
            if (!aclr0_n)     r_out_a <= '0;
            else if (clken_a) r_out_a <= r_rd_a;
         end
         assign q_a = r_out_a;
      end else begin : g_direct_a
         assign q_a = r_rd_a;
      end

      if (OUT_REG_B != 0) begin : g_oreg_b
         logic [DATA_W-1:0] r_out_b;
         always_ff @(posedge clock0 or negedge aclr0_n) begin
            if (!aclr0_n)     r_out_b <= '0;
            else if (clken_b) r_out_b <= r_rd_b;
         end
         assign q_b = r_out_b;
      end else begin : g_direct_b
         assign q_b = r_rd_b;
      end
   endgenerate

endmodule

// File: tb/tb_sync_ram_tdp.sv
// Bench for sync_ram_tdp: two configurations share one stimulus stream and are compared
// each edge against an array-based reference model, plus directed scenario values.
module tb_sync_ram_tdp;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int NB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          aclr0_n;
   logic          clken_a, wren_a, rden_a, clken_b, wren_b, rden_b;
   logic [AW-1:0] address_a, address_b;
   logic [DW-1:0] data_a, data_b;
   logic [NB-1:0] byteena_a, byteena_b;
   logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;
   logic          coll0, coll1;

   int checks = 0;
   int errors = 0;
   int pool[$];

   // u0: DEPTH 1000, A NEW_DATA direct, B OLD_DATA registered
   sync_ram_tdp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1000), .BYTE_W(8),
                  .OUT_REG_A(0), .OUT_REG_B(1), .RDW_A("NEW_DATA"), .RDW_B("OLD_DATA"),
                  .INIT_FILE("")) u0 (
      .clock0(clk), .aclr0_n(aclr0_n),
      .clken_a(clken_a), .wren_a(wren_a), .rden_a(rden_a), .address_a(address_a),
      .data_a(data_a), .byteena_a(byteena_a), .q_a(q_a0),
      .clken_b(clken_b), .wren_b(wren_b), .rden_b(rden_b), .address_b(address_b),
      .data_b(data_b), .byteena_b(byteena_b), .q_b(q_b0),
      .collision(coll0));

   // u1: DEPTH 1024, A OLD_DATA registered, B NEW_DATA direct
   sync_ram_tdp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .BYTE_W(8),
                  .OUT_REG_A(1), .OUT_REG_B(0), .RDW_A("OLD_DATA"), .RDW_B("NEW_DATA"),
                  .INIT_FILE("")) u1 (
      .clock0(clk), .aclr0_n(aclr0_n),
      .clken_a(clken_a), .wren_a(wren_a), .rden_a(rden_a), .address_a(address_a),
      .data_a(data_a), .byteena_a(byteena_a), .q_a(q_a1),
      .clken_b(clken_b), .wren_b(wren_b), .rden_b(rden_b), .address_b(address_b),
      .data_b(data_b), .byteena_b(byteena_b), .q_b(q_b1),
      .collision(coll1));

   // Reference model: per instance [k], per port [p] (0 = A, 1 = B)
   logic [DW-1:0] m_mem [2][1024];
   logic [DW-1:0] m_rd  [2][2];
   logic [DW-1:0] m_out [2][2];
   logic          m_col [2];

   function automatic int dep(input int k);
      return (k == 0) ? 1000 : 1024;
   endfunction

   function automatic bit oreg(input int k, input int p);
      return (k == 0) ? (p == 1) : (p == 0);
   endfunction

   function automatic bit oldm(input int k, input int p);
      return (k == 0) ? (p == 1) : (p == 0);
   endfunction

   function automatic logic [DW-1:0] exp_q(input int k, input int p);
      return oreg(k, p) ? m_out[k][p] : m_rd[k][p];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_col[k] = 1'b0;
         for (int p = 0; p < 2; p++) begin
            m_rd[k][p]  = '0;
            m_out[k][p] = '0;
         end
      end
   endtask

   task automatic model_edge();
      logic          ck[2], we[2], re[2], inr[2], wr[2];
      logic [AW-1:0] ad[2];
      logic [DW-1:0] dt[2];
      logic [NB-1:0] be[2];
      logic [DW-1:0] word;
      ck[0] = clken_a; we[0] = wren_a; re[0] = rden_a; ad[0] = address_a; dt[0] = data_a; be[0] = byteena_a;
      ck[1] = clken_b; we[1] = wren_b; re[1] = rden_b; ad[1] = address_b; dt[1] = data_b; be[1] = byteena_b;
      if (!aclr0_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 2; p++) begin
            inr[p] = (int'(ad[p]) < dep(k));
            wr[p]  = ck[p] && we[p] && inr[p];
            if (ck[p]) begin
               m_out[k][p] = m_rd[k][p];
               if (re[p]) begin
                  if (!inr[p]) begin
                     m_rd[k][p] = '0;
                  end else begin
                     word = m_mem[k][ad[p]];
                     if (we[p] && !oldm(k, p))
                        for (int l = 0; l < NB; l++)
                           if (be[p][l]) word[8*l +: 8] = dt[p][8*l +: 8];
                     m_rd[k][p] = word;
                  end
               end
            end
         end
         m_col[k] = wr[0] && wr[1] && (ad[0] == ad[1]);
         for (int l = 0; l < NB; l++) begin
            if (wr[1] && be[1][l] && !(wr[0] && be[0][l] && ad[0] == ad[1]))
               m_mem[k][ad[1]][8*l +: 8] = dt[1][8*l +: 8];
            if (wr[0] && be[0][l])
               m_mem[k][ad[0]][8*l +: 8] = dt[0][8*l +: 8];
         end
      end
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " u0.q_a"}, q_a0, exp_q(0, 0));
      chk({tag, " u0.q_b"}, q_b0, exp_q(0, 1));
      chk({tag, " u1.q_a"}, q_a1, exp_q(1, 0));
      chk({tag, " u1.q_b"}, q_b1, exp_q(1, 1));
      chk({tag, " u0.coll"}, {31'd0, coll0}, {31'd0, m_col[0]});
      chk({tag, " u1.coll"}, {31'd0, coll1}, {31'd0, m_col[1]});
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   task automatic idle();
      clken_a = 1'b1; wren_a = 1'b0; rden_a = 1'b0; address_a = '0; data_a = '0; byteena_a = '0;
      clken_b = 1'b1; wren_b = 1'b0; rden_b = 1'b0; address_b = '0; data_b = '0; byteena_b = '0;
   endtask

   task automatic set_a(input logic w, input logic r, input int adr, input logic [DW-1:0] d, input logic [NB-1:0] be);
      wren_a = w; rden_a = r; address_a = AW'(adr); data_a = d; byteena_a = be;
   endtask

   task automatic set_b(input logic w, input logic r, input int adr, input logic [DW-1:0] d, input logic [NB-1:0] be);
      wren_b = w; rden_b = r; address_b = AW'(adr); data_b = d; byteena_b = be;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) pool.push_back(i);
      pool.push_back(998); pool.push_back(999); pool.push_back(1000);
      pool.push_back(1010); pool.push_back(1023);

      aclr0_n = 1'b1;
      idle();
      model_reset();
      #2 aclr0_n = 1'b0;
      #1 check_all("rst_async0");
      @(negedge clk);
      set_a(1'b1, 1'b1, 5, 32'hDEADBEEF, 4'hF);
      set_b(1'b1, 1'b1, 5, 32'h12345678, 4'hF);
      tick("rst_hold0");
      idle();
      aclr0_n = 1'b1;

      // Known contents for every address used below
      foreach (pool[i]) begin
         set_a(1'b1, 1'b0, pool[i], 32'h0, 4'hF);
         tick("init");
      end

      // Reset while q is non-zero, with writes and a would-be collision held during reset
      set_a(1'b1, 1'b0, 5, 32'hCAFE0005, 4'hF); tick("rst_pre_wr");
      idle(); set_a(1'b0, 1'b1, 5, '0, '0); set_b(1'b0, 1'b1, 5, '0, '0); tick("rst_pre_rd");
      idle(); tick("rst_pre_idle");
      chk("rst_pre q_a0", q_a0, 32'hCAFE0005);
      aclr0_n = 1'b0;
      model_reset();
      #1 check_all("rst_async1");
      chk("rst_async1 q_b0", q_b0, 32'h0);
      set_a(1'b1, 1'b1, 5, 32'hDEADBEEF, 4'hF);
      set_b(1'b1, 1'b1, 5, 32'h12345678, 4'hF);
      tick("rst_hold1a");
      tick("rst_hold1b");
      chk("rst_hold coll1", {31'd0, coll1}, 32'h0);
      idle();
      aclr0_n = 1'b1;
      set_a(1'b0, 1'b1, 5, '0, '0); set_b(1'b0, 1'b1, 5, '0, '0); tick("rst_rd");
      idle(); tick("rst_rd_idle");
      chk("rst_nowrite q_a0", q_a0, 32'hCAFE0005);
      chk("rst_nowrite q_b0", q_b0, 32'hCAFE0005);

      // Basic read, registered vs direct B, then clken_b freeze
      set_a(1'b1, 1'b0, 3, 32'h000000A5, 4'hF); tick("basic_wr");
      idle(); set_b(1'b0, 1'b1, 3, '0, '0); tick("basic_rd");
      chk("basic q_b1", q_b1, 32'h000000A5);
      idle(); tick("basic_idle");
      chk("basic q_b0", q_b0, 32'h000000A5);
      idle(); clken_b = 1'b0; set_b(1'b1, 1'b1, 7, 32'hFFFFFFFF, 4'hF); tick("freeze1");
      tick("freeze2");
      chk("freeze q_b0", q_b0, 32'h000000A5);
      chk("freeze q_b1", q_b1, 32'h000000A5);

      // Byte enables with same-port read-during-write
      idle(); set_a(1'b1, 1'b0, 7, 32'h11223344, 4'hF); tick("rdw_wr");
      set_a(1'b1, 1'b1, 7, 32'hAABBCCDD, 4'b0101); tick("rdw");
      chk("rdw new q_a0", q_a0, 32'h11BB33DD);
      idle(); tick("rdw_idle");
      chk("rdw old q_a1", q_a1, 32'h11223344);
      set_a(1'b0, 1'b1, 7, '0, '0); tick("rdw_rd");
      idle(); tick("rdw_rd_idle");
      chk("rdw after q_a0", q_a0, 32'h11BB33DD);
      chk("rdw after q_a1", q_a1, 32'h11BB33DD);

      // Mixed-port read returns old data
      set_a(1'b1, 1'b0, 9, 32'h0000005A, 4'hF); set_b(1'b0, 1'b1, 9, '0, '0); tick("mixed");
      chk("mixed q_b1", q_b1, 32'h0);
      idle(); tick("mixed_idle");
      chk("mixed q_b0", q_b0, 32'h0);
      set_b(1'b0, 1'b1, 9, '0, '0); tick("mixed_rd");
      idle(); tick("mixed_rd_idle");
      chk("mixed after q_b0", q_b0, 32'h0000005A);
      chk("mixed after q_b1", q_b1, 32'h0000005A);

      // Write/write collisions
      set_a(1'b1, 1'b0, 2, 32'h00001234, 4'b0011); set_b(1'b1, 1'b0, 2, 32'h0000ABCD, 4'b0001); tick("coll1");
      chk("coll1 u0", {31'd0, coll0}, 32'h1);
      chk("coll1 u1", {31'd0, coll1}, 32'h1);
      idle(); set_a(1'b0, 1'b1, 2, '0, '0); tick("coll1_rd");
      chk("coll1 drop", {31'd0, coll0}, 32'h0);
      chk("coll1 mem", q_a0, 32'h00001234);
      set_a(1'b1, 1'b0, 2, 32'h00001234, 4'b0010); set_b(1'b1, 1'b0, 2, 32'h0000ABCD, 4'b0001); tick("coll2");
      chk("coll2 u0", {31'd0, coll0}, 32'h1);
      idle(); set_a(1'b0, 1'b1, 2, '0, '0); tick("coll2_rd");
      chk("coll2 mem", q_a0, 32'h000012CD);

      // Out-of-range on u0 (DEPTH 1000), legal on u1
      idle(); set_a(1'b1, 1'b0, 999, 32'h99999999, 4'hF); tick("oor_pre");
      set_a(1'b1, 1'b0, 1010, 32'h0A0A0A0A, 4'hF); set_b(1'b1, 1'b0, 1010, 32'h0B0B0B0B, 4'hF); tick("oor_wr");
      chk("oor coll u0", {31'd0, coll0}, 32'h0);
      chk("oor coll u1", {31'd0, coll1}, 32'h1);
      idle(); set_a(1'b0, 1'b1, 1010, '0, '0); set_b(1'b0, 1'b1, 999, '0, '0); tick("oor_rd");
      idle(); tick("oor_rd_idle");
      chk("oor q_a0", q_a0, 32'h0);
      chk("oor q_b0", q_b0, 32'h99999999);
      chk("oor q_a1", q_a1, 32'h0A0A0A0A);

      // Randomised traffic on a small address pool so collisions and RDW are frequent
      for (int n = 0; n < 400; n++) begin
         clken_a   = ($urandom_range(0, 7) != 0);
         wren_a    = 1'($urandom_range(0, 1));
         rden_a    = 1'($urandom_range(0, 1));
         address_a = AW'(pool[$urandom_range(0, pool.size() - 1)]);
         data_a    = $urandom;
         byteena_a = NB'($urandom_range(0, 15));
         clken_b   = ($urandom_range(0, 7) != 0);
         wren_b    = 1'($urandom_range(0, 1));
         rden_b    = 1'($urandom_range(0, 1));
         address_b = ($urandom_range(0, 3) == 0) ? address_a
                                                 : AW'(pool[$urandom_range(0, pool.size() - 1)]);
         data_b    = $urandom;
         byteena_b = NB'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) begin
            aclr0_n = 1'b0;
            model_reset();
            #1 check_all("rnd_rst");
            tick("rnd_in_rst");
            aclr0_n = 1'b1;
         end else begin
            tick("rnd");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
